// File: rtl/icache_fetch_ctrl_if.sv
// icache_fetch_ctrl_if: fetch request/response channel plus DDR refill channel of the instruction cache
interface icache_fetch_ctrl_if #(parameter int PC_WIDTH = 64);
  logic                pc_index_valid;
  logic [PC_WIDTH-1:0] pc_index;
  logic                pc_index_ready;
  logic                pc_operation_done;
  logic [127:0]        fetch_line;
  logic [PC_WIDTH-1:0] fetch_line_pc;
  logic                redirect_valid;
  logic                ddr_req_valid;
  logic [PC_WIDTH-1:0] ddr_req_addr;
  logic                ddr_req_ready;
  logic                ddr_resp_valid;
  logic [127:0]        ddr_resp_data;
  modport slave (
    input  pc_index_valid, pc_index, redirect_valid, ddr_req_ready, ddr_resp_valid, ddr_resp_data,
    output pc_index_ready, pc_operation_done, fetch_line, fetch_line_pc, ddr_req_valid, ddr_req_addr
  );
  modport master (
    output pc_index_valid, pc_index, redirect_valid, ddr_req_ready, ddr_resp_valid, ddr_resp_data,
    input  pc_index_ready, pc_operation_done, fetch_line, fetch_line_pc, ddr_req_valid, ddr_req_addr
  );
endinterface

// File: rtl/icache_fetch_ctrl.sv
// icache_fetch_ctrl: direct-mapped 16-byte-line instruction cache with DDR refill and redirect abort
module icache_fetch_ctrl #(
  parameter int SET_BITS = 6,
  parameter int PC_WIDTH = 64
) (
  input logic clock,
  input logic reset_n,
  icache_fetch_ctrl_if.slave bus
);
  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = PC_WIDTH - 4 - SET_BITS;
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_WAIT, READ_CACHE} state_t;
  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [PC_WIDTH-1:0] line_pc_q, line_pc_d;
  logic [PC_WIDTH-1:0] ddr_addr_q, ddr_addr_d;
  logic [127:0]        line_q, line_d;
  logic                flushed_q, flushed_d;
  logic [SETS-1:0]     valid_q, valid_d;
  logic [TAG_W-1:0]    tag_mem [SETS];
  logic [127:0]        data_mem [SETS];
  logic [PC_WIDTH-1:0] line_addr;
  logic [SET_BITS-1:0] set_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                hit, fill, aborting;
  assign line_addr = req_pc_q & ~PC_WIDTH'(15);
  assign set_idx   = line_addr[3+SET_BITS:4];
  assign req_tag   = line_addr[PC_WIDTH-1:4+SET_BITS];
  assign hit       = valid_q[set_idx] && (tag_mem[set_idx] == req_tag);
  assign fill      = (state_q == MISS_WAIT) && bus.ddr_resp_valid;
  assign aborting  = flushed_q || bus.redirect_valid;
  assign bus.pc_index_ready    = (state_q == IDLE) && !bus.redirect_valid;
  assign bus.pc_operation_done = (state_q == READ_CACHE) && !bus.redirect_valid;
  assign bus.ddr_req_valid     = (state_q == MISS_REQ);
  assign bus.ddr_req_addr      = ddr_addr_q;
  assign bus.fetch_line        = line_q;
  assign bus.fetch_line_pc     = line_pc_q;
  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    line_pc_d  = line_pc_q;
    ddr_addr_d = ddr_addr_q;
    line_d     = line_q;
    flushed_d  = flushed_q;
    valid_d    = valid_q;
    case (state_q)
      IDLE: if (bus.pc_index_valid && bus.pc_index_ready) begin
        req_pc_d = bus.pc_index;
        state_d  = LOOKUP;
      end
      LOOKUP: if (bus.redirect_valid) state_d = IDLE;
        else if (hit) begin
          line_d    = data_mem[set_idx];
          line_pc_d = line_addr;
          state_d   = READ_CACHE;
        end else begin
          ddr_addr_d = line_addr;
          state_d    = MISS_REQ;
        end
      MISS_REQ: begin
        flushed_d = aborting;
        state_d   = bus.ddr_req_ready ? MISS_WAIT : MISS_REQ;
      end
      MISS_WAIT: begin
        // An aborted refill still installs the line; it only suppresses delivery.
        flushed_d = fill ? 1'b0 : aborting;
        if (fill) begin
          valid_d[set_idx] = 1'b1;
          line_d           = bus.ddr_resp_data;
          line_pc_d        = line_addr;
          state_d          = aborting ? IDLE : READ_CACHE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      req_pc_q   <= '0;
      line_pc_q  <= '0;
      ddr_addr_q <= '0;
      line_q     <= '0;
      flushed_q  <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      line_pc_q  <= line_pc_d;
      ddr_addr_q <= ddr_addr_d;
      line_q     <= line_d;
      flushed_q  <= flushed_d;
      valid_q    <= valid_d;
    end
  end
  always_ff @(posedge clock) begin
    if (fill) begin
      tag_mem[set_idx]  <= req_tag;
      data_mem[set_idx] <= bus.ddr_resp_data;
    end
  end
endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// tb_icache_fetch_ctrl: randomized fetch/redirect/refill traffic scored against a set-indexed cache model
module tb_icache_fetch_ctrl;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;
  icache_fetch_ctrl_if #(.PC_WIDTH(64)) bus();
  icache_fetch_ctrl #(.SET_BITS(6), .PC_WIDTH(64)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  typedef struct {
    logic [127:0] line;
    logic [63:0]  pc;
    int           cyc;
  } exp_t;
  exp_t         exp_q[$];
  exp_t         mon_e;
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  bit           m_valid[64];
  logic [53:0]  m_tag[64];
  logic [127:0] m_data[64];
  logic [63:0]  pool[8] = '{64'h8000_0000, 64'h8000_0400, 64'h8000_1000, 64'h8000_0010,
                           64'h8000_0410, 64'h9000_0000, 64'h8000_03F0, 64'hFFFF_FFFF_FFFF_FFF0};
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  always @(negedge clock) begin
    if (reset_n && bus.pc_operation_done === 1'b1) begin
      chk("done_with_redirect", 128'(bus.redirect_valid), 128'(0));
      if (exp_q.size() == 0) chk("unexpected_done", 128'(1), 128'(0));
      else begin
        mon_e = exp_q.pop_front();
        chk("fetch_line", bus.fetch_line, mon_e.line);
        chk("fetch_line_pc", 128'(bus.fetch_line_pc), 128'(mon_e.pc));
        chk("done_cycle", 128'(cyc), 128'(mon_e.cyc));
      end
    end
  end
  // mode: 0 normal, 1 redirect in lookup, 2 redirect during refill, 3 redirect in delivery cycle
  task automatic do_fetch(input logic [63:0] pc, input int mode_in, input int req_dly, input int resp_dly,
                          input logic [127:0] data, input bit rd_at_resp, input bit blocked);
    int          mode = mode_in;
    int          n;
    int          s = int'((pc >> 4) % 64);
    logic [53:0] t = 54'(pc >> 10);
    logic [63:0] lpc = pc - (pc % 16);
    bit          hit = m_valid[s] && (m_tag[s] == t);
    if (hit && mode == 2) mode = 0;
    bus.pc_index = pc;
    bus.pc_index_valid = 1'b1;
    if (blocked) begin
      bus.redirect_valid = 1'b1;
      @(negedge clock);
      chk("blocked_ready", 128'(bus.pc_index_ready), 128'(0));
      tick();
      bus.redirect_valid = 1'b0;
    end
    @(negedge clock);
    chk("hs_ready", 128'(bus.pc_index_ready), 128'(1));
    n = cyc;
    if (mode == 0) exp_q.push_back('{hit ? m_data[s] : data, lpc, hit ? n + 2 : n + 4 + req_dly + resp_dly});
    tick();
    bus.pc_index_valid = 1'b0;
    bus.pc_index = {$urandom, $urandom};
    if (mode == 1) begin
      bus.redirect_valid = 1'b1;
      tick();
      bus.redirect_valid = 1'b0;
      @(negedge clock);
      chk("abort_no_req", 128'(bus.ddr_req_valid), 128'(0));
      tick();
      return;
    end
    tick();
    if (hit) begin
      if (mode == 3) bus.redirect_valid = 1'b1;
      @(negedge clock);
      chk("hit_no_req", 128'(bus.ddr_req_valid), 128'(0));
      tick();
      bus.redirect_valid = 1'b0;
      return;
    end
    for (int i = 0; i <= req_dly; i++) begin
      if (i == req_dly) begin
        bus.ddr_req_ready = 1'b1;
        if (mode == 2 && !rd_at_resp) bus.redirect_valid = 1'b1;
      end
      @(negedge clock);
      chk("req_valid", 128'(bus.ddr_req_valid), 128'(1));
      chk("req_addr", 128'(bus.ddr_req_addr), 128'(lpc));
      tick();
    end
    bus.ddr_req_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < resp_dly; i++) begin
      @(negedge clock);
      chk("req_dropped", 128'(bus.ddr_req_valid), 128'(0));
      tick();
    end
    bus.ddr_resp_valid = 1'b1;
    bus.ddr_resp_data = data;
    if (mode == 2 && rd_at_resp) bus.redirect_valid = 1'b1;
    tick();
    bus.ddr_resp_valid = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.ddr_resp_data = {$urandom, $urandom, $urandom, $urandom};
    m_valid[s] = 1'b1;
    m_tag[s] = t;
    m_data[s] = data;
    if (mode == 3) bus.redirect_valid = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
  endtask
  initial begin
    bus.pc_index_valid = 1'b0;
    bus.pc_index = '0;
    bus.redirect_valid = 1'b0;
    bus.ddr_req_ready = 1'b0;
    bus.ddr_resp_valid = 1'b0;
    bus.ddr_resp_data = '0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("rst_ready", 128'(bus.pc_index_ready), 128'(1));
    chk("rst_done", 128'(bus.pc_operation_done), 128'(0));
    chk("rst_req_valid", 128'(bus.ddr_req_valid), 128'(0));
    chk("rst_req_addr", 128'(bus.ddr_req_addr), 128'(0));
    chk("rst_line", bus.fetch_line, 128'(0));
    chk("rst_line_pc", 128'(bus.fetch_line_pc), 128'(0));
    tick();
    do_fetch(64'h8000_0000, 0, 0, 3, {16{8'hA5}}, 1'b0, 1'b0);
    do_fetch(64'h8000_0008, 0, 0, 0, '0, 1'b0, 1'b0);
    do_fetch(64'h8000_0400, 0, 1, 1, {4{32'hB0B0_0001}}, 1'b0, 1'b0);
    do_fetch(64'h8000_0000, 0, 0, 2, {4{32'hC0C0_0002}}, 1'b0, 1'b0);
    do_fetch(64'h8000_1000, 2, 0, 2, {4{32'hD00D_0003}}, 1'b1, 1'b0);
    do_fetch(64'h8000_1000, 0, 0, 0, '0, 1'b0, 1'b1);
    do_fetch(64'h8000_1004, 3, 0, 0, '0, 1'b0, 1'b0);
    do_fetch(64'h8000_0010, 1, 0, 0, '0, 1'b0, 1'b0);
    do_fetch(64'h8000_0010, 2, 2, 1, {4{32'hE0E0_0004}}, 1'b0, 1'b0);
    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(0, 2)) begin
        bus.redirect_valid = 1'($urandom_range(0, 1));
        bus.ddr_resp_valid = ($urandom_range(0, 3) == 0);
        bus.ddr_resp_data = {$urandom, $urandom, $urandom, $urandom};
        tick();
      end
      bus.redirect_valid = 1'b0;
      bus.ddr_resp_valid = 1'b0;
      do_fetch(pool[$urandom_range(0, 7)] | 64'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0,
               int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), {$urandom, $urandom, $urandom, $urandom},
               1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
    end
    do_fetch(64'h8000_0000, 0, 0, 0, {4{32'h1234_5678}}, 1'b0, 1'b0);
    bus.pc_index = 64'h8000_2000;
    bus.pc_index_valid = 1'b1;
    tick();
    bus.pc_index_valid = 1'b0;
    tick();
    @(negedge clock);
    chk("pre_reset_req_valid", 128'(bus.ddr_req_valid), 128'(1));
    reset_n = 1'b0;
    #1;
    chk("async_rst_req_valid", 128'(bus.ddr_req_valid), 128'(0));
    chk("async_rst_ready", 128'(bus.pc_index_ready), 128'(1));
    chk("async_rst_line", bus.fetch_line, 128'(0));
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    tick();
    do_fetch(64'h8000_0000, 0, 1, 2, {4{32'h0F0F_5A5A}}, 1'b0, 1'b0);
    do_fetch(64'h8000_000C, 0, 0, 0, '0, 1'b0, 1'b0);
    repeat (3) tick();
    chk("missing_done", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
